// File: rtl/alu_regfile_pkg.sv
// Shared definitions for the sequenced register-file/ALU datapath:
// op codes, flag bit positions and sequencer states.
// Optional feature macro used by the top: ALU_REGFILE_ZERO_REG_EN.
package alu_regfile_pkg;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_XOR = 4'd2;
  localparam logic [3:0] OP_NOR = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_SUB = 4'd5;
  localparam logic [3:0] OP_SLT = 4'd6;
  localparam logic [3:0] OP_SLL = 4'd7;
  localparam logic [3:0] OP_SRL = 4'd8;
  localparam logic [3:0] OP_SRA = 4'd9;

  localparam int unsigned FLAG_ZF = 3;
  localparam int unsigned FLAG_SF = 2;
  localparam int unsigned FLAG_OF = 1;
  localparam int unsigned FLAG_CF = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RR   = 2'd1,
    ST_EX   = 2'd2,
    ST_WB   = 2'd3
  } state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: logic, add/sub, signed compare and shifts, plus
// {ZF,SF,OF,CF}. Shift amount comes from the low bits of operand A.
module alu_core
  import alu_regfile_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        op,
  output logic [DATA_W-1:0] f,
  output logic [3:0]        flags
);

  localparam int unsigned SH_W = $clog2(DATA_W);

  logic [SH_W-1:0] shamt;
  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  assign shamt = a[SH_W-1:0];

  // Result mux and flag generation
  always_comb begin
    sum   = {1'b0, a} + {1'b0, b};
    diff  = {1'b0, a} - {1'b0, b};
    f     = '0;
    flags = '0;
    case (op)
      OP_AND: f = a & b;
      OP_OR:  f = a | b;
      OP_XOR: f = a ^ b;
      OP_NOR: f = ~(a | b);
      OP_ADD: begin
        f              = sum[DATA_W-1:0];
        flags[FLAG_CF] = sum[DATA_W];
        flags[FLAG_OF] = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
      end
      OP_SUB: begin
        f              = diff[DATA_W-1:0];
        flags[FLAG_CF] = diff[DATA_W];
        flags[FLAG_OF] = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
      end
      OP_SLT: f = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL: f = b << shamt;
      OP_SRL: f = b >> shamt;
      OP_SRA: f = $signed(b) >>> shamt;
      default: f = '0;
    endcase
    flags[FLAG_ZF] = (f == '0);
    flags[FLAG_SF] = f[DATA_W-1];
  end

endmodule

// File: rtl/alu_regfile_seq.sv
// Register file + ALU with an internal IDLE/RR/EX/WB sequencer and a
// start/done handshake. Define ALU_REGFILE_ZERO_REG_EN to make register 0
// a constant zero.
module alu_regfile_seq
  import alu_regfile_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3:0]        alu_op,
  input  logic [ADDR_W-1:0] r_addr_a,
  input  logic [ADDR_W-1:0] r_addr_b,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic              reg_write,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        flags
);

  localparam int unsigned NUM_REGS = 2**ADDR_W;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] rf_q [NUM_REGS];
  logic [DATA_W-1:0] rf_d [NUM_REGS];
  logic [3:0]        op_q, op_d;
  logic [ADDR_W-1:0] a_lat_q, a_lat_d;
  logic [ADDR_W-1:0] b_lat_q, b_lat_d;
  logic [ADDR_W-1:0] w_lat_q, w_lat_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [3:0]        flags_q, flags_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              write_ok;
  logic [DATA_W-1:0] alu_f;
  logic [3:0]        alu_flags;

  alu_core #(.DATA_W(DATA_W)) u_alu (
    .a     (a_q),
    .b     (b_q),
    .op    (op_q),
    .f     (alu_f),
    .flags (alu_flags)
  );

`ifdef ALU_REGFILE_ZERO_REG_EN
  // r0 is never written, so it keeps its reset value of zero
  assign write_ok = (w_lat_q != '0);
`else
  assign write_ok = 1'b1;
`endif

  // Sequencer next-state, operand/result capture and register writeback
  always_comb begin
    state_d  = state_q;
    rf_d     = rf_q;
    op_d     = op_q;
    a_lat_d  = a_lat_q;
    b_lat_d  = b_lat_q;
    w_lat_d  = w_lat_q;
    we_d     = we_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = alu_op;
          a_lat_d = r_addr_a;
          b_lat_d = r_addr_b;
          w_lat_d = w_addr;
          we_d    = reg_write;
          state_d = ST_RR;
        end
      end
      ST_RR: begin
        a_d     = rf_q[a_lat_q];
        b_d     = rf_q[b_lat_q];
        state_d = ST_EX;
      end
      ST_EX: begin
        result_d = alu_f;
        flags_d  = alu_flags;
        state_d  = ST_WB;
      end
      ST_WB: begin
        if (we_q && write_ok) rf_d[w_lat_q] = result_q;
        if (start) begin
          op_d    = alu_op;
          a_lat_d = r_addr_a;
          b_lat_d = r_addr_b;
          w_lat_d = w_addr;
          we_d    = reg_write;
          state_d = ST_RR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Status outputs are registered, so they are derived from the next state
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_WB);
  end

  // All state; async reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      for (int unsigned i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
      op_q     <= '0;
      a_lat_q  <= '0;
      b_lat_q  <= '0;
      w_lat_q  <= '0;
      we_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      flags_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rf_q     <= rf_d;
      op_q     <= op_d;
      a_lat_q  <= a_lat_d;
      b_lat_q  <= b_lat_d;
      w_lat_q  <= w_lat_d;
      we_q     <= we_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign flags  = flags_q;

endmodule

// File: tb/tb_alu_regfile_seq.sv
// Directed bench for alu_regfile_seq. Register contents are built up from
// the all-zero reset state using ALU ops; expected values are hand-derived
// and expressed in terms of DW so the bench also covers DW=16, AW=3.
module tb_alu_regfile_seq;

  parameter int unsigned DW = 32;
  parameter int unsigned AW = 5;

  localparam logic [DW-1:0] ONES   = '1;
  localparam logic [DW-1:0] MAXPOS = ONES >> 1;
  localparam logic [DW-1:0] MINNEG = ~MAXPOS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [3:0]    alu_op = '0;
  logic [AW-1:0] r_addr_a = '0;
  logic [AW-1:0] r_addr_b = '0;
  logic [AW-1:0] w_addr = '0;
  logic          reg_write = 1'b0;
  logic          busy;
  logic          done;
  logic [DW-1:0] result;
  logic [3:0]    flags;

  int total = 0;
  int bad   = 0;

  alu_regfile_seq #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .alu_op    (alu_op),
    .r_addr_a  (r_addr_a),
    .r_addr_b  (r_addr_b),
    .w_addr    (w_addr),
    .reg_write (reg_write),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input int a, input int b, input int w, input bit we);
    alu_op    = op;
    r_addr_a  = AW'(a);
    r_addr_b  = AW'(b);
    w_addr    = AW'(w);
    reg_write = we;
  endtask

  // One full operation; inputs are scrambled right after acceptance
  task automatic run_op(input string tag, input logic [3:0] op, input int a, input int b,
                        input int w, input bit we, input logic [DW-1:0] er, input logic [3:0] ef);
    @(negedge clk);
    start = 1'b1;
    drive(op, a, b, w, we);
    @(posedge clk); #1;
    start = 1'b0;
    drive(~op, a + 1, b + 2, w + 3, ~we);
    check({tag, ".busy0"}, 64'(busy), 64'd1);
    @(posedge clk); #1;
    check({tag, ".done1"}, 64'(done), 64'd0);
    @(posedge clk); #1;
    check({tag, ".done2"}, 64'(done), 64'd1);
    check({tag, ".res"},   64'(result), 64'(er));
    check({tag, ".flg"},   64'(flags),  64'(ef));
    @(posedge clk); #1;
    check({tag, ".done3"}, 64'(done), 64'd0);
    check({tag, ".idle"},  64'(busy), 64'd0);
  endtask

  initial begin
    #12;
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.res",  64'(result), 64'd0);
    check("rst.flg",  64'(flags), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // seed registers
    run_op("nor",  4'd3, 0, 0, 1, 1, ONES,   4'b0100);  // r1 = -1
    run_op("sub1", 4'd5, 0, 1, 2, 1, DW'(1), 4'b0001);  // r2 = 1 (borrow)
    run_op("srl",  4'd8, 2, 1, 3, 1, MAXPOS, 4'b0000);  // r3 = MAXPOS
    run_op("addov",4'd4, 3, 2, 7, 0, MINNEG, 4'b0110);
    run_op("add2", 4'd4, 2, 2, 6, 1, DW'(2), 4'b0000);  // r6 = 2
    run_op("sll4", 4'd7, 2, 6, 4, 1, DW'(4), 4'b0000);  // r4 = 4
    run_op("add5", 4'd4, 4, 2, 4, 1, DW'(5), 4'b0000);  // r4 = 5
    run_op("add7", 4'd4, 4, 6, 5, 1, DW'(7), 4'b0000);  // r5 = 7
    run_op("subneg", 4'd5, 4, 5, 0, 0, ONES - DW'(1), 4'b0101);
    run_op("subeq",  4'd5, 4, 4, 0, 0, '0, 4'b1000);
    run_op("slt1", 4'd6, 1, 2, 0, 0, DW'(1), 4'b0000);
    run_op("slt0", 4'd6, 2, 1, 0, 0, '0, 4'b1000);
    run_op("sra",  4'd9, 2, 1, 0, 0, ONES, 4'b0100);
    run_op("xor",  4'd2, 1, 3, 0, 0, MINNEG, 4'b0100);
    run_op("op12", 4'd12, 1, 1, 0, 0, '0, 4'b1000);

    // reg_write=0 leaves destination unchanged
    run_op("nowr", 4'd0, 1, 1, 4, 0, ONES, 4'b0100);
    run_op("nowrrd", 4'd1, 4, 0, 0, 0, DW'(5), 4'b0000);

    // shift amount uses only the low address bits of A
    run_op("sll32", 4'd7, 4, 2, 6, 1, DW'(32), 4'b0000);
    run_op("add33", 4'd4, 6, 2, 6, 1, DW'(33), 4'b0000);
    run_op("sll33", 4'd7, 6, 5, 0, 0, DW'(14), 4'b0000);

    // start held during RR/EX must be ignored
    @(negedge clk);
    start = 1'b1; drive(4'd4, 4, 2, 0, 0);          // 5+1 = 6
    @(posedge clk); #1; drive(4'd3, 0, 0, 4, 1);     // RR, start still high
    @(posedge clk); #1;                              // EX, start still high
    @(posedge clk); #1; start = 1'b0;                // WB
    check("ign.res", 64'(result), 64'd6);
    check("ign.done", 64'(done), 64'd1);
    @(posedge clk); #1;
    check("ign.idle", 64'(busy), 64'd0);
    run_op("ign.r4", 4'd1, 4, 0, 0, 0, DW'(5), 4'b0000);

    // back-to-back with read-after-write through r7
    @(negedge clk);
    start = 1'b1; drive(4'd4, 4, 5, 7, 1);           // r7 = 12
    @(posedge clk); #1; drive(4'd4, 7, 2, 0, 0);     // next: r7 + 1
    @(posedge clk); #1;
    check("b2b.d1", 64'(done), 64'd0);
    @(posedge clk); #1;
    check("b2b.d2", 64'(done), 64'd1);
    check("b2b.r1", 64'(result), 64'd12);
    @(posedge clk); #1; start = 1'b0;
    check("b2b.d3", 64'(done), 64'd0);
    check("b2b.busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    check("b2b.d4", 64'(done), 64'd0);
    @(posedge clk); #1;
    check("b2b.d5", 64'(done), 64'd1);
    check("b2b.r2", 64'(result), 64'd13);
    check("b2b.f2", 64'(flags), 64'd0);
    @(posedge clk); #1;
    check("b2b.d6", 64'(done), 64'd0);

    // reset asserted during EX
    @(negedge clk);
    start = 1'b1; drive(4'd3, 0, 0, 7, 1);
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    check("mrst.busy", 64'(busy), 64'd0);
    check("mrst.done", 64'(done), 64'd0);
    check("mrst.res",  64'(result), 64'd0);
    check("mrst.flg",  64'(flags), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    run_op("mrst.r1", 4'd1, 1, 1, 0, 0, '0, 4'b1000);
    run_op("mrst.r7", 4'd1, 7, 5, 0, 0, '0, 4'b1000);

    // register 0 behaviour
    run_op("r0wr", 4'd3, 0, 0, 0, 1, ONES, 4'b0100);
`ifdef ALU_REGFILE_ZERO_REG_EN
    run_op("r0rd", 4'd1, 0, 0, 0, 0, '0, 4'b1000);
`else
    run_op("r0rd", 4'd1, 0, 0, 0, 0, ONES, 4'b0100);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_regfile_seq.md
Name: alu_regfile_seq

Overview:
- Parametrised, single-clock successor of the 32-bit register-file/ALU datapath top.
- Replaces the three external phase strobes (register read, ALU latch, writeback) with an internal sequencer driven by a start/done handshake.
- Width and register count are generic. Sits between the front-panel/controller logic and the display/flag LEDs.

Parameters:
DATA_W, 32, datapath and register width (>=8)
ADDR_W, 5, register address width; NUM_REGS = 2**ADDR_W

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request one operation; sampled in IDLE or WB
alu_op  input  4  operation code (encodings in package)
r_addr_a  input  ADDR_W  source register A
r_addr_b  input  ADDR_W  source register B
w_addr  input  ADDR_W  destination register
reg_write  input  1  1 = write result to w_addr in WB
busy  output  1  high while in RR, EX or WB
done  output  1  one-cycle pulse in WB
result  output  DATA_W  registered ALU result (F)
flags  output  4  registered {ZF,SF,OF,CF}

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all NUM_REGS registers, A, B, result, flags, latched op/addresses = 0; busy=done=0. Reset mid-operation aborts it; no write occurs.
- FSM states: IDLE, RR, EX, WB.
  - IDLE: start=1 latches alu_op, addresses and reg_write, then -> RR; otherwise stay.
  - RR: A <= rf[a_lat], B <= rf[b_lat]; -> EX.
  - EX: result <= alu(A,B), flags <= alu flags; -> WB.
  - WB: if write latch set, rf[w_lat] <= result; done=1. start=1 in WB latches a new op and -> RR (back-to-back); else -> IDLE.
- Latency and throughput: start accepted at edge 0; result/flags valid after edge 2; done high during cycle 3. Back-to-back throughput is 1 op per 3 cycles.
- start in RR/EX is ignored; inputs changing after acceptance have no effect.
- Read-after-write: a WB write lands at the WB edge, so the following RR reads the new value; no bypass is needed.
- result/flags hold their value until the next EX.
- ALU ops (all DATA_W wide):
  - 0 AND, 1 OR, 2 XOR, 3 NOR
  - 4 ADD, 5 SUB (A-B)
  - 6 SLT: signed, result 1/0
  - 7 SLL: B << A[clog2(DATA_W)-1:0]
  - 8 SRL, 9 SRA: B shifted by the same amount
  - 10-15 result 0
- Flags:
  - ZF = (result==0); SF = result MSB.
  - ADD: CF = carry-out, OF = signed overflow.
  - SUB: CF = borrow (A<B unsigned), OF = signed overflow.
  - All other ops: CF=OF=0.

Optional Feature:
- Macro ALU_REGFILE_ZERO_REG_EN.
- Defined: register 0 always reads 0 and writes to it are discarded (flags still update).
- Undefined: register 0 is an ordinary register.

Decomposition:
- Package alu_regfile_pkg: op-code localparams, flag bit indices (ZF=3,SF=2,OF=1,CF=0), FSM state encoding.
- One sub-module, alu_core: purely combinational, parametrised by DATA_W, producing result and the four flags.
- Register array, A/B/result/flag registers and FSM live in the top.

Test Plan:
- Reset: rst_n low mid-EX -> busy=0, done=0, result=0, flags=0, all registers read 0 on subsequent ops.
- Seed via ops, then ADD r1=0x7FFFFFFF + r2=1 -> result 0x80000000, flags {0,1,1,0}; done exactly at cycle 3 after start.
- SUB r3=5 - r4=7 -> 0xFFFFFFFE, SF=1, CF=1, OF=0. SUB equal operands -> ZF=1.
- Back-to-back: start held high, op1 writes r5, op2 reads r5 -> op2 sees op1's value; done pulses every 3 cycles.
- start asserted during RR/EX -> ignored; reg_write=0 -> destination unchanged. SLL with A=33 (DATA_W=32) -> shift by 1.
- ALU_REGFILE_ZERO_REG_EN: write 0x55 to r0 then read r0 -> 0. Without the macro -> 0x55. Repeat key cases with DATA_W=16, ADDR_W=3.
